// File: rtl/nn_stage_mem_pp.sv
// nn_stage_mem_pp: per-stage tap/bias RAMs plus a ping-pong data RAM with bank-level handshake
module nn_stage_mem_pp_ram #(
    parameter int W = 32,
    parameter int DEPTH = 16,
    parameter int A = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [A-1:0] rd_addr,
    output logic [W-1:0] rd_word
);
    localparam logic [A:0] N = DEPTH[A:0];
    logic [W-1:0] mem [DEPTH];
    logic wr_ok, rd_ok;
    assign wr_ok = wr_en && ({1'b0, wr_addr} < N);
    assign rd_ok = {1'b0, rd_addr} < N;
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_addr] <= wr_data;
    // A same-cycle write to the read address is forwarded (write-first)
    assign rd_word = !rd_ok ? '0 : (wr_ok && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
endmodule

module nn_stage_mem_pp_rdpipe #(
    parameter int W = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         v
);
    logic [W-1:0] d1, d2;
    logic v1, v2;
    always_ff @(posedge clk)
        if (reset) begin
            d1 <= '0;
            d2 <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= en;
            v2 <= v1;
            if (en) d1 <= d;
            if (v1) d2 <= d1;
        end
    assign q = (LAT == 2) ? d2 : d1;
    assign v = (LAT == 2) ? v2 : v1;
endmodule

module nn_stage_mem_pp #(
    parameter int TAP_W = 384,
    parameter int TAP_DEPTH = 32,
    parameter int BIAS_W = 32,
    parameter int BIAS_DEPTH = 16,
    parameter int DATA_W = 32,
    parameter int DATA_DEPTH = 512,
    parameter int RD_LAT = 1,
    localparam int TA = $clog2(TAP_DEPTH),
    localparam int BA = $clog2(BIAS_DEPTH),
    localparam int DA = $clog2(DATA_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tap_wr_en,
    input  logic [TA-1:0]     tap_wr_addr,
    input  logic [TAP_W-1:0]  tap_wr_data,
    input  logic              tap_rd_en,
    input  logic [TA-1:0]     tap_rd_addr,
    output logic [TAP_W-1:0]  tap_rd_data,
    output logic              tap_rd_valid,
    input  logic              bias_wr_en,
    input  logic [BA-1:0]     bias_wr_addr,
    input  logic [BIAS_W-1:0] bias_wr_data,
    input  logic              bias_rd_en,
    input  logic [BA-1:0]     bias_rd_addr,
    output logic [BIAS_W-1:0] bias_rd_data,
    output logic              bias_rd_valid,
    input  logic              data_wr_en,
    input  logic [DA-1:0]     data_wr_addr,
    input  logic [DATA_W-1:0] data_wr_data,
    input  logic              data_wr_done,
    output logic              data_wr_ready,
    input  logic              data_rd_en,
    input  logic [DA-1:0]     data_rd_addr,
    output logic [DATA_W-1:0] data_rd_data,
    output logic              data_rd_valid,
    input  logic              data_rd_done,
    output logic              data_bank_avail,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              err_overflow,
    output logic              err_underrun
);
    logic [1:0] full, full_n;
    logic wr_go, rd_go, dw;
    logic [TAP_W-1:0] tap_word;
    logic [BIAS_W-1:0] bias_word;
    logic [DATA_W-1:0] w0, w1;

    nn_stage_mem_pp_ram #(.W(TAP_W), .DEPTH(TAP_DEPTH), .A(TA)) u_tap (
        .clk(clk), .wr_en(tap_wr_en), .wr_addr(tap_wr_addr), .wr_data(tap_wr_data),
        .rd_addr(tap_rd_addr), .rd_word(tap_word));
    nn_stage_mem_pp_ram #(.W(BIAS_W), .DEPTH(BIAS_DEPTH), .A(BA)) u_bias (
        .clk(clk), .wr_en(bias_wr_en), .wr_addr(bias_wr_addr), .wr_data(bias_wr_data),
        .rd_addr(bias_rd_addr), .rd_word(bias_word));
    nn_stage_mem_pp_ram #(.W(DATA_W), .DEPTH(DATA_DEPTH), .A(DA)) u_d0 (
        .clk(clk), .wr_en(dw && !wr_bank), .wr_addr(data_wr_addr), .wr_data(data_wr_data),
        .rd_addr(data_rd_addr), .rd_word(w0));
    nn_stage_mem_pp_ram #(.W(DATA_W), .DEPTH(DATA_DEPTH), .A(DA)) u_d1 (
        .clk(clk), .wr_en(dw && wr_bank), .wr_addr(data_wr_addr), .wr_data(data_wr_data),
        .rd_addr(data_rd_addr), .rd_word(w1));

    nn_stage_mem_pp_rdpipe #(.W(TAP_W), .LAT(RD_LAT)) p_tap (
        .clk(clk), .reset(reset), .en(tap_rd_en), .d(tap_word), .q(tap_rd_data), .v(tap_rd_valid));
    nn_stage_mem_pp_rdpipe #(.W(BIAS_W), .LAT(RD_LAT)) p_bias (
        .clk(clk), .reset(reset), .en(bias_rd_en), .d(bias_word), .q(bias_rd_data), .v(bias_rd_valid));
    // Underrun reads still go through, returning whatever the drain bank holds
    nn_stage_mem_pp_rdpipe #(.W(DATA_W), .LAT(RD_LAT)) p_data (
        .clk(clk), .reset(reset), .en(data_rd_en), .d(rd_bank ? w1 : w0), .q(data_rd_data), .v(data_rd_valid));

    assign dw = data_wr_en && data_wr_ready;

    always_ff @(posedge clk)
        if (reset) begin
            full <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            err_overflow <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            full <= full_n;
            wr_bank <= wr_bank ^ wr_go;
            rd_bank <= rd_bank ^ rd_go;
            err_overflow <= err_overflow | (data_wr_en & ~data_wr_ready);
            err_underrun <= err_underrun | (data_rd_en & ~data_bank_avail);
        end

    // wr_go needs an empty bank and rd_go a full one, so they never hit the same bank
    always_comb begin
        wr_go = data_wr_done && data_wr_ready;
        rd_go = data_rd_done && data_bank_avail;
        full_n = (full | ({1'b0, wr_go} << wr_bank)) & ~({1'b0, rd_go} << rd_bank);
    end

    always_comb begin
        data_wr_ready = !full[wr_bank];
        data_bank_avail = full[rd_bank];
    end
endmodule

// File: doc/nn_stage_mem_pp.md
Name: nn_stage_mem_pp

Overview:
- Parametrised per-stage memory for the NN pipeline. Holds three arrays: tap (weights), bias, and data (activations).
- Tap and bias are single-bank synchronous RAMs.
- Data is a ping-pong, double-buffered RAM. The loader fills one bank while the compute stage reads the other, under a bank-level handshake.
- Read latency is configurable. All read ports return a valid strobe.
- Sits between the stage loader/controller and the MAC datapath of each layer stage.

Parameters:
- TAP_W, 384, tap word width (bits)
- TAP_DEPTH, 32, tap words
- BIAS_W, 32, bias word width
- BIAS_DEPTH, 16, bias words
- DATA_W, 32, data word width
- DATA_DEPTH, 512, data words per bank
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- Address widths: TA=$clog2(TAP_DEPTH), BA=$clog2(BIAS_DEPTH), DA=$clog2(DATA_DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tap_wr_en  in  1  tap write strobe
- tap_wr_addr  in  TA  tap write address
- tap_wr_data  in  TAP_W  tap write data
- tap_rd_en  in  1  tap read strobe
- tap_rd_addr  in  TA  tap read address
- tap_rd_data  out  TAP_W  tap read data
- tap_rd_valid  out  1  tap read data valid
- bias_wr_en, bias_wr_addr[BA], bias_wr_data[BIAS_W]  in  bias write port, same semantics as tap
- bias_rd_en, bias_rd_addr[BA]  in  bias read request
- bias_rd_data[BIAS_W], bias_rd_valid  out  bias read response
- data_wr_en  in  1  write into the current fill bank
- data_wr_addr  in  DA  data write address
- data_wr_data  in  DATA_W  data write data
- data_wr_done  in  1  pulse: fill bank complete
- data_wr_ready  out  1  fill bank is free
- data_rd_en  in  1  read from the current drain bank
- data_rd_addr  in  DA  data read address
- data_rd_data  out  DATA_W  data read data
- data_rd_valid  out  1  data read data valid
- data_rd_done  in  1  pulse: drain bank consumed
- data_bank_avail  out  1  drain bank holds a full set
- wr_bank  out  1  current fill bank index
- rd_bank  out  1  current drain bank index
- err_overflow  out  1  sticky error flag
- err_underrun  out  1  sticky error flag

Behaviour:
- Reset (synchronous, active-high)
  - Clears full[1:0], wr_bank, rd_bank, every rd_data, every rd_valid, err_overflow and err_underrun to 0.
  - RAM contents are not cleared.
  - Reset asserted mid-operation discards any in-flight reads: valid is 0 on the next cycle.
- Reads (all arrays)
  - Synchronous. rd_data and rd_valid appear RD_LAT cycles after rd_en.
  - RD_LAT=2 adds one output register stage.
  - Back-to-back reads are fully pipelined, one per cycle.
  - When rd_valid is 0, rd_data holds its last value.
- Read-during-write to the same address in the same cycle returns the NEW data (write-first). This applies to tap, to bias, and to data when both ports target the same physical bank.
- Data bank handshake
  - Flags: full[b] per bank.
  - data_wr_ready = !full[wr_bank].
  - data_bank_avail = full[rd_bank].
  - Writes go to bank wr_bank; reads come from bank rd_bank.
  - data_wr_done while data_wr_ready: full[wr_bank] is set to 1 and wr_bank toggles.
  - data_wr_done while !data_wr_ready: ignored.
  - data_rd_done while data_bank_avail: full[rd_bank] is cleared to 0 and rd_bank toggles.
  - data_rd_done while !data_bank_avail: ignored.
  - wr_done and rd_done in the same cycle: both take effect on their respective banks. With both banks full, only rd_done can act; it frees the bank the writer needs next cycle.
- Bank states (encoded by full[1:0]): EMPTY (00), ONE (01 or 10), BOTH (11).
  - EMPTY -> ONE on wr_done.
  - ONE -> BOTH on wr_done.
  - ONE -> EMPTY on rd_done.
  - BOTH -> ONE on rd_done.
- Errors
  - data_wr_en while !data_wr_ready: write is dropped and err_overflow is set.
  - data_rd_en while !data_bank_avail: read is performed anyway (stale bank data) and err_underrun is set.
  - Both flags stay set until reset.
- Address wrap: an address at or beyond DEPTH (non-power-of-2 depths) is ignored on write and returns 0 on read.
- Flag and bank updates take effect on the cycle after the done pulse.

Test Plan:
- Tap path, RD_LAT=1: write 0xA5..A5 to addr 3; read addr 3 next cycle -> tap_rd_valid=1 and tap_rd_data=0xA5..A5 exactly 1 cycle later.
- Bias path, RD_LAT=2: write and read addr 5 in the same cycle with 0x1234 (addr 5 previously 0) -> 0x1234 returned exactly 2 cycles later (write-first).
- Ping-pong: fill bank0 with 0..511 and pulse wr_done -> wr_bank=1, rd_bank=0, data_bank_avail=1. Fill bank1 with 1000+i while reading bank0 -> reads return 0..511 and are unaffected by bank1 writes.
- Backpressure: fill both banks -> data_wr_ready=0. A data_wr_en now sets err_overflow and leaves memory unchanged. rd_done -> data_wr_ready=1 next cycle.
- Simultaneous: in state ONE (bank0 full, writer on bank1), assert wr_done and rd_done together -> next cycle full=2'b10, wr_bank=0, rd_bank=1, no error flags set.
- Reset mid-read: issue a data read, then assert reset the next cycle -> data_rd_valid=0, full=0, banks=0, err flags=0. Post-reset data_wr_ready=1 and data_bank_avail=0.
